// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/align front end.
// Build option: FETCH_RVC_EN enables compressed-parcel alignment.
package fetch_pkg;

   localparam int INST_W   = 32;
   localparam int PARCEL_W = 16;

   typedef enum logic [1:0] {
      ALIGNED = 2'd0,
      RESIDUE = 2'd1,
      SKIP_LO = 2'd2
   } align_state_e;

   function automatic logic is_compressed(input logic [1:0] lo);
      return lo != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Small word buffer between instruction memory and the align FSM.
// Synchronous flush clears all entries in one cycle.
module fetch_word_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              flush,
   input  logic              push,
   input  logic [INST_W-1:0] push_data,
   input  logic              pop,
   output logic [INST_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [INST_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch request, response buffering and half-word alignment control.
// Build option: FETCH_RVC_EN enables the residue register and RVC FSM.
module fetch_align_ctrl
   import fetch_pkg::*;
#(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              id_ready,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_o,
   output logic [31:0]       inst_pc,
   output logic              inst_is_c
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [31:0]       fetch_addr;
   logic [31:0]       pc_q;
   logic [31:0]       redir_pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    in_use;
   logic [INST_W-1:0] head;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fire;
   logic              drop;
   logic              take;
   logic              accept;
   logic              cand_valid;
   logic              cand_c;
   logic [INST_W-1:0] cand_inst;

   assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req  = ~reset & ~redirect_valid
                    & (in_use < (CNT_W + 1)'(FIFO_DEPTH));
   assign imem_addr = fetch_addr;
   assign fire      = imem_req & imem_gnt;
   assign drop      = imem_rvalid & (discard != '0);
   assign fifo_push = imem_rvalid & ~drop & ~redirect_valid;
   assign take      = id_ready & ~redirect_valid & ~reset;

   fetch_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .flush     (reset | redirect_valid),
      .push      (fifo_push),
      .push_data (imem_rdata),
      .pop       (fifo_pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign inst_valid = cand_valid & ~redirect_valid & ~reset;
   assign inst_o     = inst_valid ? cand_inst : '0;
   assign inst_is_c  = inst_valid & cand_c;
   assign inst_pc    = pc_q;
   assign accept     = inst_valid & id_ready;

`ifdef FETCH_RVC_EN
   align_state_e          state;
   logic [PARCEL_W-1:0]   residue;
   logic                  unused_rpc;

   assign unused_rpc = redirect_pc[0];
   assign redir_pc   = {redirect_pc[31:1], 1'b0};

   always_comb begin
      cand_valid = 1'b0;
      cand_c     = 1'b0;
      cand_inst  = '0;
      fifo_pop   = 1'b0;
      unique case (state)
         ALIGNED: begin
            cand_valid = ~fifo_empty;
            fifo_pop   = ~fifo_empty & take;
            if (is_compressed(head[1:0])) begin
               cand_c    = 1'b1;
               cand_inst = {{PARCEL_W{1'b0}}, head[PARCEL_W-1:0]};
            end else begin
               cand_inst = head;
            end
         end
         RESIDUE: begin
            if (is_compressed(residue[1:0])) begin
               cand_valid = 1'b1;
               cand_c     = 1'b1;
               cand_inst  = {{PARCEL_W{1'b0}}, residue};
            end else begin
               cand_valid = ~fifo_empty;
               cand_inst  = {head[PARCEL_W-1:0], residue};
               fifo_pop   = ~fifo_empty & take;
            end
         end
         SKIP_LO: begin
            fifo_pop = ~fifo_empty & ~redirect_valid & ~reset;
         end
         default: begin
            cand_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ALIGNED;
         residue <= '0;
      end else if (redirect_valid) begin
         state   <= redirect_pc[1] ? SKIP_LO : ALIGNED;
         residue <= '0;
      end else begin
         unique case (state)
            ALIGNED: begin
               if (accept && cand_c) begin
                  residue <= head[INST_W-1:PARCEL_W];
                  state   <= RESIDUE;
               end
            end
            RESIDUE: begin
               if (accept) begin
                  if (cand_c) begin
                     state <= ALIGNED;
                  end else begin
                     residue <= head[INST_W-1:PARCEL_W];
                  end
               end
            end
            SKIP_LO: begin
               if (!fifo_empty) begin
                  residue <= head[INST_W-1:PARCEL_W];
                  state   <= RESIDUE;
               end
            end
            default: state <= ALIGNED;
         endcase
      end
   end
`else
   logic unused_rpc;

   assign unused_rpc = ^redirect_pc[1:0];
   assign redir_pc   = {redirect_pc[31:2], 2'b00};
   assign cand_valid = ~fifo_empty;
   assign cand_c     = 1'b0;
   assign cand_inst  = head;
   assign fifo_pop   = ~fifo_empty & take;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_addr  <= RESET_PC;
         pc_q        <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_rvalid);
         if (redirect_valid) begin
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            pc_q       <= redir_pc;
            discard    <= outstanding - CNT_W'(imem_rvalid);
         end else begin
            if (fire) begin
               fetch_addr <= fetch_addr + 32'd4;
            end
            if (drop) begin
               discard <= discard - CNT_W'(1);
            end
            if (accept) begin
               pc_q <= pc_q + (cand_c ? 32'd2 : 32'd4);
            end
         end
      end
   end

   // The outstanding+buffered cap means a response always has room.
   a_no_overflow: assert property (
      @(posedge clk) disable iff (reset) !(fifo_push && fifo_full)
   );

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl with a 1-cycle memory model.
// Expectations follow the FETCH_RVC_EN build setting.
module tb_fetch_align_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_ready;
   logic        inst_valid;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic        inst_is_c;

   int n_chk  = 0;
   int n_fail = 0;
   logic        resp_en;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] pend [$];

   always #5 clk = ~clk;

   fetch_align_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_ready       (id_ready),
      .inst_valid     (inst_valid),
      .inst_o         (inst_o),
      .inst_pc        (inst_pc),
      .inst_is_c      (inst_is_c)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[31:2], 2'b11};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        fired;
      logic [31:0] fa;
      #1;
      fired = imem_req & imem_gnt;
      fa    = imem_addr;
      @(posedge clk);
      #1;
      if (fired) pend.push_back(fa);
      if (resp_en && pend.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      reset = 1'b0;
   endtask

   task automatic take(input string tag, input logic [31:0] ei,
                       input logic [31:0] ep, input logic ec);
      for (int i = 0; i < 30 && inst_valid !== 1'b1; i++) tick();
      chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
      chk({tag, ".inst"}, inst_o, ei);
      chk({tag, ".pc"}, inst_pc, ep);
      chk({tag, ".c"}, 32'(inst_is_c), 32'(ec));
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      #1;
      chk("redir.req", 32'(imem_req), 32'd0);
      chk("redir.valid", 32'(inst_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      redirect_pc = '0;
      imem_gnt    = 1'b1;
      resp_en     = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;

      // reset state and gnt stall
      mem.delete();
      mem[32'h0] = 32'h0000_0013;
      mem[32'h4] = 32'h0000_0013;
      reset = 1'b1;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      chk("rst.req", 32'(imem_req), 32'd0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.valid", 32'(inst_valid), 32'd0);
      chk("rst.inst", inst_o, 32'h0);
      chk("rst.pc", inst_pc, 32'h0);
      chk("rst.c", 32'(inst_is_c), 32'd0);
      do_reset();
      imem_gnt = 1'b0;
      tick();
      chk("nognt.req", 32'(imem_req), 32'd1);
      chk("nognt.addr", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      take("t1a", 32'h0000_0013, 32'h0, 1'b0);
      take("t1b", 32'h0000_0013, 32'h4, 1'b0);

      // two compressed parcels in one word
      do_reset();
      mem.delete();
      mem[32'h0] = 32'h4501_4505;
      mem[32'h4] = 32'h0000_0013;
`ifdef FETCH_RVC_EN
      take("t2a", 32'h0000_4505, 32'h0, 1'b1);
      take("t2b", 32'h0000_4501, 32'h2, 1'b1);
`else
      take("t2a", 32'h4501_4505, 32'h0, 1'b0);
`endif
      take("t2c", 32'h0000_0013, 32'h4, 1'b0);

`ifdef FETCH_RVC_EN
      // 32-bit instruction straddling a word boundary
      do_reset();
      mem.delete();
      mem[32'h0] = 32'h0013_4505;
      mem[32'h4] = 32'h1111_0000;
      take("t3a", 32'h0000_4505, 32'h0, 1'b1);
      take("t3b", 32'h0000_0013, 32'h2, 1'b0);
      take("t3c", 32'h0000_1111, 32'h6, 1'b1);
      take("t3d", 32'h0000_000B, 32'h8, 1'b0);
`endif

      // half-word redirect target
      do_reset();
      mem.delete();
      mem[32'h100] = 32'hAAAA_BBBB;
      repeat (4) tick();
      redirect(32'h0000_0102);
      #1;
      chk("t4.addr", imem_addr, 32'h100);
      chk("t4.valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_RVC_EN
      chk("t4.pc", inst_pc, 32'h102);
      take("t4a", 32'h0000_AAAA, 32'h102, 1'b1);
`else
      chk("t4.pc", inst_pc, 32'h100);
      take("t4a", 32'hAAAA_BBBB, 32'h100, 1'b0);
`endif
      take("t4b", 32'h0000_0107, 32'h104, 1'b0);

      // stale in-flight responses are discarded
      do_reset();
      mem.delete();
      resp_en = 1'b0;
      repeat (3) tick();
      chk("t5.req", 32'(imem_req), 32'd0);
      redirect(32'h0000_0200);
      resp_en = 1'b1;
      take("t5a", 32'h0000_0203, 32'h200, 1'b0);
      take("t5b", 32'h0000_0207, 32'h204, 1'b0);

      // back-to-back redirects, last wins
      redirect(32'h0000_0300);
      redirect(32'h0000_0400);
      take("t6a", 32'h0000_0403, 32'h400, 1'b0);

      // backpressure with a full buffer
      do_reset();
      mem.delete();
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         chk("t7.req", 32'(imem_req), 32'd0);
         chk("t7.inst", inst_o, 32'h0000_0003);
         tick();
      end
      take("t7a", 32'h0000_0003, 32'h0, 1'b0);
      take("t7b", 32'h0000_0007, 32'h4, 1'b0);
      take("t7c", 32'h0000_000B, 32'h8, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
